// File: rtl/vga_timing_gen.sv
// Raster timing generator: scans DrawX/DrawY over the full frame and produces
// registered sync, blank and line/frame start markers aligned to the position.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       primed_q, primed_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       line_q, line_d;
    logic       frame_q, frame_d;
    logic [10:0] hn_x, vn_x;

    // The first advance after reset only announces (0,0); later advances step.
    always_comb begin
        hc_d     = hc_q;
        vc_d     = vc_q;
        primed_d = primed_q;
        line_d   = 1'b0;
        frame_d  = 1'b0;
        if (pix_en) begin
            if (!primed_q) begin
                primed_d = 1'b1;
                line_d   = 1'b1;
                frame_d  = 1'b1;
            end else if ({1'b0, hc_q} == H_LAST) begin
                hc_d   = 10'd0;
                line_d = 1'b1;
                if ({1'b0, vc_q} == V_LAST) begin
                    vc_d    = 10'd0;
                    frame_d = 1'b1;
                end else begin
                    vc_d = vc_q + 10'd1;
                end
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
        hn_x    = {1'b0, hc_d};
        vn_x    = {1'b0, vc_d};
        blank_d = (hn_x < H_VIS) && (vn_x < V_VIS);
        hs_d    = !((hn_x >= H_SYNC_BEG) && (hn_x < H_SYNC_END));
        vs_d    = !((vn_x >= V_SYNC_BEG) && (vn_x < V_SYNC_END));
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc_q     <= 10'd0;
            vc_q     <= 10'd0;
            primed_q <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            blank_q  <= 1'b1;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            primed_q <= primed_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            blank_q  <= blank_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size instance and a shrunken one share
// stimulus; expected outputs come from the advance count via raster arithmetic.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic pix_en  = 1'b0;

    logic [9:0] d_x, d_y, s_x, s_y;
    logic d_hs, d_vs, d_blank, d_ls, d_fs;
    logic s_hs, s_vs, s_blank, s_ls, s_fs;

    vga_timing_gen u_def (
        .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs), .blank(d_blank),
        .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_blank),
        .line_start(s_ls), .frame_start(s_fs)
    );

    int n_vec = 0;
    int n_err = 0;
    int adv   = 0;
    int cyc   = 0;

    int s_fs_per = 0, s_fs_last = -1;
    int d_ls_per = 0, d_ls_last = -1;
    int d_hs_w   = 0, d_hs_run  = -1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: position is (advances-1) modulo frame size, scanned row-major.
    task automatic check_inst(input string nm, input int a, input bit adv_now,
                              input int hv, input int hf, input int hsw, input int hb,
                              input int vv, input int vf, input int vsw, input int vb,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic hs, input logic vs, input logic bl,
                              input logic ls, input logic fs);
        int ht, vt, p, ex, ey;
        logic e_hs, e_vs, e_bl, e_ls, e_fs;
        ht   = hv + hf + hsw + hb;
        vt   = vv + vf + vsw + vb;
        p    = (a == 0) ? 0 : ((a - 1) % (ht * vt));
        ex   = p % ht;
        ey   = p / ht;
        e_bl = (ex < hv) && (ey < vv);
        e_hs = !((ex >= hv + hf) && (ex < hv + hf + hsw));
        e_vs = !((ey >= vv + vf) && (ey < vv + vf + vsw));
        e_ls = adv_now && (ex == 0);
        e_fs = adv_now && (p == 0);
        check_val({nm, "_DrawX"}, 32'(x), 32'(ex));
        check_val({nm, "_DrawY"}, 32'(y), 32'(ey));
        check_val({nm, "_hs"}, 32'(hs), 32'(e_hs));
        check_val({nm, "_vs"}, 32'(vs), 32'(e_vs));
        check_val({nm, "_blank"}, 32'(bl), 32'(e_bl));
        check_val({nm, "_line_start"}, 32'(ls), 32'(e_ls));
        check_val({nm, "_frame_start"}, 32'(fs), 32'(e_fs));
    endtask

    task automatic set_meas(input int fs_per, input int ls_per, input int hs_w);
        s_fs_per = fs_per; s_fs_last = -1;
        d_ls_per = ls_per; d_ls_last = -1;
        d_hs_w   = hs_w;   d_hs_run  = -1;
    endtask

    task automatic step(input logic rst_n, input logic en);
        bit adv_now;
        reset_n = rst_n;
        pix_en  = en;
        @(posedge clk);
        adv_now = rst_n && en;
        if (!rst_n) adv = 0;
        else if (en) adv++;
        @(negedge clk);
        cyc++;
        check_inst("def", adv, adv_now, 640, 16, 96, 48, 480, 10, 2, 33,
                   d_x, d_y, d_hs, d_vs, d_blank, d_ls, d_fs);
        check_inst("sml", adv, adv_now, 16, 2, 3, 3, 8, 1, 2, 2,
                   s_x, s_y, s_hs, s_vs, s_blank, s_ls, s_fs);
        if (s_fs) begin
            if (s_fs_per != 0 && s_fs_last >= 0)
                check_val("sml_frame_period", 32'(cyc - s_fs_last), 32'(s_fs_per));
            s_fs_last = cyc;
        end
        if (d_ls) begin
            if (d_ls_per != 0 && d_ls_last >= 0)
                check_val("def_line_period", 32'(cyc - d_ls_last), 32'(d_ls_per));
            d_ls_last = cyc;
        end
        if (d_hs) begin
            if (d_hs_w != 0 && d_hs_run > 0)
                check_val("def_hs_width", 32'(d_hs_run), 32'(d_hs_w));
            d_hs_run = 0;
        end else if (d_hs_run >= 0) begin
            d_hs_run++;
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)));

        set_meas(312, 800, 96);
        for (int i = 0; i < 2000; i++) step(1'b1, 1'b1);

        set_meas(624, 1600, 192);
        for (int i = 0; i < 3400; i++) step(1'b1, 1'(i % 2 == 0));

        set_meas(0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) step(1'b0, 1'($urandom_range(0, 1)));
            else step(1'b1, 1'($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 137; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 400; i++) step(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
